// File: rtl/instr_sequencer.sv
// Instruction sequencer: program counter, instruction register and control-state
// register, with fetch stalling while a requested instruction word is not yet valid.
module instr_sequencer #(
  parameter int PC_W   = 8,
  parameter int RST_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      NS,
  input  logic [1:0]      PS,
  input  logic            IL,
  input  logic [15:0]     instr_in,
  input  logic            instr_valid,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      state,
  output logic [3:0]      opcode,
  output logic [3:0]      DR,
  output logic [3:0]      SA,
  output logic [3:0]      SB,
  output logic            stall
);

  localparam logic [PC_W-1:0] RST_PC_V = PC_W'(RST_PC);

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INC    = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JUMP   = 2'b11
  } pc_ctl_e;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     ir_q;
  logic [3:0]      state_q;
  logic            stall_q;
  logic            advance;

  // Branch offset is the 8-bit signed field {DR,SB}; sign-extended or truncated to PC_W.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] base,
                                                    input logic [15:0]     ir);
    logic signed [7:0] off;
    off = signed'({ir[11:8], ir[3:0]});
    return base + PC_W'(off);
  endfunction

  assign advance = !(IL && !instr_valid);

  always_comb begin
    pc_next = pc_q;
    unique case (pc_ctl_e'(PS))
      PC_HOLD:   pc_next = pc_q;
      PC_INC:    pc_next = pc_q + PC_W'(1);
      PC_BRANCH: pc_next = branch_target(pc_q, ir_q);
      PC_JUMP:   pc_next = jump_addr;
      default:   pc_next = pc_q;
    endcase
  end

  // A pending fetch freezes every register except stall until the word arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RST_PC_V;
      ir_q    <= 16'h0000;
      state_q <= 4'h0;
      stall_q <= 1'b0;
    end else if (advance) begin
      pc_q    <= pc_next;
      state_q <= NS;
      stall_q <= 1'b0;
      if (IL) ir_q <= instr_in;
    end else begin
      stall_q <= 1'b1;
    end
  end

  assign pc     = pc_q;
  assign state  = state_q;
  assign stall  = stall_q;
  assign opcode = ir_q[15:12];
  assign DR     = ir_q[11:8];
  assign SA     = ir_q[7:4];
  assign SB     = ir_q[3:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, hand-written reset/stall sequences,
// and randomized cycles checked against an arithmetic reference model.
module tb_instr_sequencer;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      NS;
  logic [1:0]      PS;
  logic            IL;
  logic [15:0]     instr_in;
  logic            instr_valid;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] pc;
  logic [3:0]      state;
  logic [3:0]      opcode;
  logic [3:0]      DR;
  logic [3:0]      SA;
  logic [3:0]      SB;
  logic            stall;

  instr_sequencer #(.PC_W(PC_W), .RST_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .NS(NS), .PS(PS), .IL(IL), .instr_in(instr_in),
    .instr_valid(instr_valid), .jump_addr(jump_addr), .pc(pc), .state(state),
    .opcode(opcode), .DR(DR), .SA(SA), .SB(SB), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_pc;
  logic [15:0] m_ir;
  logic [3:0]  m_st;
  logic        m_stall;

  typedef struct {
    logic        il;
    logic        vld;
    logic [15:0] instr;
    logic [1:0]  ps;
    logic [3:0]  ns;
    logic [7:0]  jmp;
    logic [7:0]  e_pc;
    logic [15:0] e_ir;
    logic [3:0]  e_st;
    logic        e_stall;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [15:0] e_ir,
                           input logic [3:0] e_st, input logic e_stall);
    check({tag, ".pc"},    32'(pc), 32'(e_pc));
    check({tag, ".ir"},    32'({opcode, DR, SA, SB}), 32'(e_ir));
    check({tag, ".state"}, 32'(state), 32'(e_st));
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
  endtask

  // Drive a cycle's inputs, let one rising edge pass, sample 1 time unit later.
  task automatic apply(input logic il, input logic vld, input logic [15:0] instr,
                       input logic [1:0] ps, input logic [3:0] ns, input logic [7:0] jmp);
    IL = il; instr_valid = vld; instr_in = instr; PS = ps; NS = ns; jump_addr = jmp;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 16'h0000; m_st = 4'h0; m_stall = 1'b0;
  endtask

  task automatic model_step(input logic il, input logic vld, input logic [15:0] instr,
                            input logic [1:0] ps, input logic [3:0] ns, input logic [7:0] jmp);
    int off;
    if (il && !vld) begin
      m_stall = 1'b1;
    end else begin
      case (ps)
        2'd1: m_pc = (m_pc + 1) % 256;
        2'd2: begin
          off = int'({m_ir[11:8], m_ir[3:0]});
          if (off >= 128) off = off - 256;
          m_pc = (m_pc + off + 256) % 256;
        end
        2'd3: m_pc = int'(jmp);
        default: ;
      endcase
      if (il) m_ir = instr;
      m_st    = ns;
      m_stall = 1'b0;
    end
  endtask

  initial begin
    //            il vld instr     ps     ns    jmp    e_pc   e_ir      e_st  e_stall
    tbl[0]  = '{1'b1, 1'b1, 16'h1234, 2'b01, 4'h1, 8'h00, 8'h01, 16'h1234, 4'h1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'h0F0E, 2'b11, 4'h2, 8'h10, 8'h10, 16'h0F0E, 4'h2, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 2'b10, 4'h3, 8'h00, 8'h0E, 16'h0F0E, 4'h3, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0703, 2'b11, 4'h4, 8'h90, 8'h90, 16'h0703, 4'h4, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'hFFFF, 2'b10, 4'h6, 8'h00, 8'h03, 16'h0703, 4'h6, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'hABCD, 2'b01, 4'h5, 8'h00, 8'h03, 16'h0703, 4'h6, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 16'hABCD, 2'b01, 4'h5, 8'h00, 8'h03, 16'h0703, 4'h6, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'hABCD, 2'b01, 4'h5, 8'h00, 8'h03, 16'h0703, 4'h6, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 16'hABCD, 2'b01, 4'h5, 8'h00, 8'h04, 16'hABCD, 4'h5, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h1111, 2'b11, 4'h7, 8'hA5, 8'hA5, 16'hABCD, 4'h7, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h2222, 2'b11, 4'h8, 8'hFF, 8'hFF, 16'hABCD, 4'h8, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h3333, 2'b01, 4'h9, 8'h00, 8'h00, 16'hABCD, 4'h9, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h4444, 2'b00, 4'hA, 8'h77, 8'h00, 16'hABCD, 4'hA, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 16'h5FFF, 2'b10, 4'hB, 8'h00, 8'hBD, 16'h5FFF, 4'hB, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 2'b10, 4'hC, 8'h00, 8'hBC, 16'h5FFF, 4'hC, 1'b0};

    IL = 1'b0; instr_valid = 1'b0; instr_in = 16'h0; PS = 2'b00; NS = 4'h0; jump_addr = '0;

    // Reset asserted before any clock edge
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_all("reset", 8'h00, 16'h0000, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].il, tbl[i].vld, tbl[i].instr, tbl[i].ps, tbl[i].ns, tbl[i].jmp);
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_st, tbl[i].e_stall);
    end

    // Asynchronous reset during a stall, with no clock edge
    apply(1'b0, 1'b0, 16'h0000, 2'b11, 4'h3, 8'h42);
    check_all("jmp42", 8'h42, 16'h5FFF, 4'h3, 1'b0);
    apply(1'b1, 1'b0, 16'h9876, 2'b01, 4'h5, 8'h00);
    check_all("stall42", 8'h42, 16'h5FFF, 4'h3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 16'h0000, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1'b1, 16'h1234, 2'b01, 4'h1, 8'h00);
    check_all("post_rst", 8'h01, 16'h1234, 4'h1, 1'b0);

    // Randomized cycles against the reference model
    model_reset();
    model_step(1'b1, 1'b1, 16'h1234, 2'b01, 4'h1, 8'h00);
    for (int n = 0; n < 400; n++) begin
      logic        r_il, r_vld;
      logic [15:0] r_instr;
      logic [1:0]  r_ps;
      logic [3:0]  r_ns;
      logic [7:0]  r_jmp;
      r_il    = 1'($urandom_range(0, 1));
      r_vld   = ($urandom_range(0, 3) != 0);
      r_instr = 16'($urandom);
      r_ps    = 2'($urandom_range(0, 3));
      r_ns    = 4'($urandom_range(0, 15));
      r_jmp   = 8'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all($sformatf("rnd_rst%0d", n), 8'(m_pc), m_ir, m_st, m_stall);
        rst_n = 1'b1;
      end
      apply(r_il, r_vld, r_instr, r_ps, r_ns, r_jmp);
      model_step(r_il, r_vld, r_instr, r_ps, r_ns, r_jmp);
      check_all($sformatf("rnd%0d", n), 8'(m_pc), m_ir, m_st, m_stall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
